// File: rtl/spi_pixel_receiver.sv
// spi_pixel_receiver
//   Main-FPGA end of the nibble-serial inter-FPGA pixel link. Synchronizes the
//   asynchronous DCLK / CS / data / final-pixel inputs into clk_in, assembles
//   two nibbles (high first) into one pixel, tags it with a raster address and
//   flags end-of-frame and malformed transactions.
//
//   Optional build macro: SPI_RX_ERR_COUNT_EN
//     Adds rx_err_count_out (saturating error count) and rx_pixel_count_out
//     (wrapping emitted-pixel count).
//
//   DATA_WIDTH must equal 2*LINES.
//
//   Output timing: pixel_valid_out, pixel_out, frame_done_out and rx_error_out
//   are decoded from the current state. During the EMIT cycle hcount_out and
//   vcount_out still hold the address of the pixel being presented. They
//   advance on the clock edge that ends EMIT. There is no backpressure: a
//   consumer must take the pixel in the cycle pixel_valid_out is high.

module spi_pixel_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 90,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [LINES-1:0]            chip_data_in,
    input  logic                        chip_clk_in,
    input  logic                        chip_sel_in,
    input  logic                        final_pixel_in,
    output logic [DATA_WIDTH-1:0]       pixel_out,
    output logic                        pixel_valid_out,
    output logic [$clog2(H_PIXELS)-1:0] hcount_out,
    output logic [$clog2(V_PIXELS)-1:0] vcount_out,
    output logic                        frame_done_out,
    output logic                        rx_error_out
`ifdef SPI_RX_ERR_COUNT_EN
    ,
    output logic [15:0]                 rx_err_count_out,
    output logic [23:0]                 rx_pixel_count_out
`endif
);

    localparam int HW = $clog2(H_PIXELS);
    localparam int VW = $clog2(V_PIXELS);
    localparam logic [HW-1:0] H_LAST = HW'(H_PIXELS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_PIXELS - 1);

    // The reset value of the CS synchronizer reads as "CS high" until the real
    // input has propagated, so WAIT_IDLE holds off for SYNC_STAGES+1 cycles.
    // Without this, a CS that is already low at reset would look like a fresh
    // falling edge and the tail of an old transaction would be captured.
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FLUSH_N = FW'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_NIB0      = 3'd2,
        S_NIB1      = 3'd3,
        S_EMIT      = 3'd4,
        S_WAIT_END  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    // Synchronizer chains; index 0 samples the pin, SYNC_STAGES-1 is the output.
    logic [SYNC_STAGES-1:0]            r_dclk_sync;
    logic [SYNC_STAGES-1:0]            r_cs_sync;
    logic [SYNC_STAGES-1:0]            r_fin_sync;
    logic [SYNC_STAGES-1:0][LINES-1:0] r_data_sync;
    logic                              r_dclk_dly;
    logic                              r_cs_dly;

    logic [FW-1:0]         r_flush;
    logic [DATA_WIDTH-1:0] r_pix;
    logic                  r_final;
    logic                  r_cs_pend;
    logic [HW-1:0]         r_hcount;
    logic [VW-1:0]         r_vcount;

    logic             w_dclk_rise;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_cs_level;
    logic [LINES-1:0] w_data;
    logic             w_fin;
    logic             w_flushed;
    logic             w_at_last;
    logic             w_end_cs;

    assign w_cs_level  = r_cs_sync[SYNC_STAGES-1];
    assign w_dclk_rise = r_dclk_sync[SYNC_STAGES-1] & ~r_dclk_dly;
    assign w_cs_fall   = ~w_cs_level & r_cs_dly;
    assign w_cs_rise   = w_cs_level & ~r_cs_dly;
    assign w_data      = r_data_sync[SYNC_STAGES-1];
    assign w_fin       = r_fin_sync[SYNC_STAGES-1];
    assign w_flushed   = (r_flush == FLUSH_N);
    assign w_at_last   = (r_hcount == H_LAST) && (r_vcount == V_LAST);
    // A CS rise seen while finishing NIB1 or during EMIT ends the transaction
    // once WAIT_END is reached.
    assign w_end_cs    = w_cs_rise | r_cs_pend;

    // Input synchronizers plus one delay flop each on DCLK and CS for edges.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dclk_sync <= '0;
            r_cs_sync   <= '1;
            r_fin_sync  <= '0;
            r_data_sync <= '0;
            r_dclk_dly  <= 1'b0;
            r_cs_dly    <= 1'b1;
        end else begin
            r_dclk_sync[0] <= chip_clk_in;
            r_cs_sync[0]   <= chip_sel_in;
            r_fin_sync[0]  <= final_pixel_in;
            r_data_sync[0] <= chip_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dclk_sync[i] <= r_dclk_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_fin_sync[i]  <= r_fin_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_dclk_dly <= r_dclk_sync[SYNC_STAGES-1];
            r_cs_dly   <= w_cs_level;
        end
    end

    // Post-reset flush counter: counts up once, then holds.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_flush <= '0;
        end else if (r_state == S_WAIT_IDLE && !w_flushed) begin
            r_flush <= r_flush + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic. With DCLK and CS rising together, the DCLK edge is
    // taken first: in NIB0 the result is still an abort, and in NIB1 the pixel
    // completes and the CS edge is remembered in r_cs_pend.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_IDLE: if (w_flushed && w_cs_level) w_next = S_IDLE;
            S_IDLE:      if (w_cs_fall)               w_next = S_NIB0;
            S_NIB0: begin
                if (w_cs_rise)        w_next = S_IDLE;
                else if (w_dclk_rise) w_next = S_NIB1;
            end
            S_NIB1: begin
                if (w_dclk_rise)      w_next = S_EMIT;
                else if (w_cs_rise)   w_next = S_IDLE;
            end
            S_EMIT:      w_next = S_WAIT_END;
            S_WAIT_END:  if (w_end_cs) w_next = S_IDLE;
            default:     w_next = S_WAIT_IDLE;
        endcase
    end

    // FSM outputs: pixel strobe, end-of-frame and malformed-transaction strobe.
    always_comb begin
        pixel_valid_out = 1'b0;
        pixel_out       = '0;
        frame_done_out  = 1'b0;
        rx_error_out    = 1'b0;
        case (r_state)
            S_NIB0: rx_error_out = w_cs_rise;
            S_NIB1: rx_error_out = w_cs_rise & ~w_dclk_rise;
            S_EMIT: begin
                pixel_valid_out = 1'b1;
                pixel_out       = r_pix;
                frame_done_out  = r_final | w_at_last;
                rx_error_out    = w_dclk_rise;
            end
            S_WAIT_END: rx_error_out = w_dclk_rise;
            default: ;
        endcase
    end

    // Nibble assembly and final-flag latch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pix   <= '0;
            r_final <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_pix   <= '0;
                        r_final <= 1'b0;
                    end
                end
                S_NIB0: begin
                    if (w_dclk_rise) begin
                        r_pix[DATA_WIDTH-1 -: LINES] <= w_data;
                        r_final                      <= w_fin;
                    end
                end
                S_NIB1: begin
                    if (w_dclk_rise) begin
                        r_pix[LINES-1:0] <= w_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remember a CS rise that lands while the pixel is still being emitted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cs_pend <= 1'b0;
        end else begin
            case (r_state)
                S_NIB1:  r_cs_pend <= w_dclk_rise & w_cs_rise;
                S_EMIT:  r_cs_pend <= r_cs_pend | w_cs_rise;
                default: r_cs_pend <= 1'b0;
            endcase
        end
    end

    // Raster address: advances on the edge ending EMIT; final flag resyncs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_state == S_EMIT) begin
            if (r_final || w_at_last) begin
                r_hcount <= '0;
                r_vcount <= '0;
            end else if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;

`ifdef SPI_RX_ERR_COUNT_EN
    logic [15:0] r_err_count;
    logic [23:0] r_pixel_count;

    // Saturating error counter and wrapping emitted-pixel counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err_count   <= '0;
            r_pixel_count <= '0;
        end else begin
            if (rx_error_out && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (pixel_valid_out) begin
                r_pixel_count <= r_pixel_count + 24'd1;
            end
        end
    end

    assign rx_err_count_out   = r_err_count;
    assign rx_pixel_count_out = r_pixel_count;
`endif

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Bench for spi_pixel_receiver, built with a reduced 16x8 raster so full
// frames fit in a short run. Stimulus pushes the expected {frame_done, v, h,
// pixel} into exp_q; the monitor pops and compares on every pixel_valid_out.
//
// Sender interface: CS active low; data and final_pixel_in change while DCLK
// is low; the receiver samples on each DCLK rising edge.

module tb_spi_pixel_receiver;

  localparam int TH = 16;
  localparam int TV = 8;
  localparam int HW = $clog2(TH);
  localparam int VW = $clog2(TV);
  localparam int EW = 1 + VW + HW + 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [3:0]    data;
  logic          dclk;
  logic          cs;
  logic          fin;
  logic [7:0]    pixel_out;
  logic          pixel_valid_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          frame_done_out;
  logic          rx_error_out;
`ifdef SPI_RX_ERR_COUNT_EN
  logic [15:0]   rx_err_count_out;
  logic [23:0]   rx_pixel_count_out;
`endif

  spi_pixel_receiver #(
    .DATA_WIDTH (8),
    .LINES      (4),
    .H_PIXELS   (TH),
    .V_PIXELS   (TV),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .chip_data_in   (data),
    .chip_clk_in    (dclk),
    .chip_sel_in    (cs),
    .final_pixel_in (fin),
    .pixel_out      (pixel_out),
    .pixel_valid_out(pixel_valid_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .frame_done_out (frame_done_out),
    .rx_error_out   (rx_error_out)
`ifdef SPI_RX_ERR_COUNT_EN
    ,
    .rx_err_count_out  (rx_err_count_out),
    .rx_pixel_count_out(rx_pixel_count_out)
`endif
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_err = 0;
  int act_err = 0;
  int exp_h = 0;
  int exp_v = 0;
  int k = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference raster model: push expectation, then advance the address.
  task automatic push_pix(input logic [7:0] pix, input logic f);
    logic done;
    done = f || (exp_h == TH-1 && exp_v == TV-1);
    exp_q.push_back({done, VW'(exp_v), HW'(exp_h), pix});
    if (done) begin
      exp_h = 0;
      exp_v = 0;
    end else if (exp_h == TH-1) begin
      exp_h = 0;
      exp_v = exp_v + 1;
    end else begin
      exp_h = exp_h + 1;
    end
  endtask

  // driver: one CS-framed transaction with n_edges DCLK rising edges
  task automatic xfer(input logic [7:0] pix, input int n_edges, input logic f, input int hp);
    @(negedge clk) cs = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < n_edges; i++) begin
      if (i == 0)      data = pix[7:4];
      else if (i == 1) data = pix[3:0];
      else             data = 4'hF;
      fin = (i == 0) ? f : 1'b0;
      repeat (hp) @(negedge clk);
      dclk = 1'b1;
      repeat (hp) @(negedge clk);
      dclk = 1'b0;
    end
    fin = 1'b0;
    repeat (hp) @(negedge clk);
    cs = 1'b1;
    repeat (hp + 8) @(negedge clk);
  endtask

  task automatic good_pix(input logic [7:0] pix, input logic f, input int hp);
    push_pix(pix, f);
    xfer(pix, 2, f, hp);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (rx_error_out) act_err++;
      if (pixel_valid_out) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: got pix=%h h=%0d v=%0d, required no pixel",
                   pixel_out, hcount_out, vcount_out);
        end else begin
          e = exp_q.pop_front();
          if ({frame_done_out, vcount_out, hcount_out, pixel_out} !== e) begin
            n_fail++;
            $display("FAIL pixel: got done=%0b v=%0d h=%0d pix=%h, required done=%0b v=%0d h=%0d pix=%h",
                     frame_done_out, vcount_out, hcount_out, pixel_out,
                     e[EW-1], e[EW-2 -: VW], e[HW+7 -: HW], e[7:0]);
          end
        end
      end else if (frame_done_out) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_done_no_valid: got frame_done=1, required 0");
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"}, int'(pixel_out), 0);
    check({tag, "_valid"}, int'(pixel_valid_out), 0);
    check({tag, "_hcount"}, int'(hcount_out), 0);
    check({tag, "_vcount"}, int'(vcount_out), 0);
    check({tag, "_done"}, int'(frame_done_out), 0);
    check({tag, "_err"}, int'(rx_error_out), 0);
  endtask

  // stimulus
  initial begin
    rst = 1'b1; data = 4'h0; dclk = 1'b0; cs = 1'b1; fin = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // basic pixels at the slow sender rate
    good_pix(8'hA5, 1'b0, 50);
    good_pix(8'h3C, 1'b0, 50);

    // abort after one nibble: error, no pixel, address held
    exp_err++;
    xfer(8'hF0, 1, 1'b0, 4);
    check("abort_err", act_err, exp_err);
    good_pix(8'h7E, 1'b0, 4);

    // three DCLK edges: one pixel then one error
    exp_err++;
    push_pix(8'h5A, 1'b0);
    xfer(8'h5A, 3, 1'b0, 4);
    check("extra_edge_err", act_err, exp_err);

    // stream up to (10,5), final flag there forces resync to (0,0)
    while (!(exp_h == 10 && exp_v == 5)) begin
      good_pix(8'(k * 37 + 11), 1'b0, 4);
      k++;
    end
    good_pix(8'hC3, 1'b1, 4);
    check("resync_model_h", exp_h, 0);
    good_pix(8'h11, 1'b0, 4);

    // full frame with final flag on the last pixel
    while (!(exp_h == TH-1 && exp_v == TV-1)) begin
      good_pix(8'(k * 37 + 11), 1'b0, 4);
      k++;
    end
    good_pix(8'hE1, 1'b1, 4);
    good_pix(8'h22, 1'b0, 4);

    // full frame ending by natural wrap, no final flag
    while (!(exp_h == TH-1 && exp_v == TV-1)) begin
      good_pix(8'(k * 29 + 3), 1'b0, 4);
      k++;
    end
    good_pix(8'hD4, 1'b0, 4);
    good_pix(8'h33, 1'b0, 4);
    check("pre_reset_err", act_err, exp_err);

    // reset mid-transaction with CS held low
    good_pix(8'h44, 1'b0, 4);
    @(negedge clk) cs = 1'b0;
    repeat (4) @(negedge clk);
    data = 4'hA;
    repeat (4) @(negedge clk);
    dclk = 1'b1;
    repeat (4) @(negedge clk);
    dclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data = (i == 0) ? 4'h5 : 4'h6;
      repeat (4) @(negedge clk);
      dclk = 1'b1;
      repeat (4) @(negedge clk);
      dclk = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("rst_mid_hcount", int'(hcount_out), 0);
    cs = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_err", act_err, exp_err);
    exp_h = 0;
    exp_v = 0;
    good_pix(8'h96, 1'b0, 4);
    good_pix(8'h69, 1'b0, 4);

    repeat (50) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("err_total", act_err, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pixel_receiver.md
Name: spi_pixel_receiver

Overview:
- Main-FPGA endpoint of the inter-FPGA pixel link. It is the stage directly downstream of the peripheral FPGA's nibble-serial SPI sender.
- It synchronizes the incoming DCLK, CS, data lines and final-pixel flag into the main clock domain, and assembles each two-nibble transaction (high nibble first) into one 8-bit depth pixel.
- It tags each pixel with a raster address for the frame buffer writer and pulses an end-of-frame strobe.

Parameters:
- DATA_WIDTH, 8, assembled pixel width; must equal 2*LINES.
- LINES, 4, SPI data lines; one nibble per DCLK rising edge.
- H_PIXELS, 160, pixels per row.
- V_PIXELS, 90, rows per frame.
- SYNC_STAGES, 2, flops in each input synchronizer; minimum 2.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  synchronous active-high reset.
- chip_data_in  input  LINES  SPI data from the peripheral (asynchronous).
- chip_clk_in  input  1  DCLK from the peripheral (asynchronous).
- chip_sel_in  input  1  CS from the peripheral, active low (asynchronous).
- final_pixel_in  input  1  peripheral final-pixel flag (asynchronous); high during the first nibble of the last pixel.
- pixel_out  output  DATA_WIDTH  assembled pixel, {first nibble, second nibble}.
- pixel_valid_out  output  1  one-cycle strobe; pixel_out and address valid.
- hcount_out  output  $clog2(H_PIXELS)  column of pixel_out.
- vcount_out  output  $clog2(V_PIXELS)  row of pixel_out.
- frame_done_out  output  1  one-cycle strobe, coincident with valid of the last pixel in a frame.
- rx_error_out  output  1  one-cycle strobe on a malformed transaction.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset values:
  - pixel_out=0, pixel_valid_out=0, frame_done_out=0, rx_error_out=0.
  - hcount_out=0, vcount_out=0.
  - Synchronizer flops: CS flops=1, all others=0.
  - State=WAIT_IDLE.
- Synchronizers: every asynchronous input passes through SYNC_STAGES flops.
  - Edge detection compares the last sync stage against one extra delay flop.
  - A DCLK rising edge is (sync=1, delayed=0). A CS falling edge and a CS rising edge are detected the same way.
  - Data and final flag are sampled from the last sync stage in the cycle the DCLK rising edge is detected. The sender updates data on DCLK falling edges with 50-cycle half-periods, so data is stable there.
- State machine:
  - WAIT_IDLE: entered from reset. Moves to IDLE only once synced CS=1, so a transaction already in progress at reset is discarded.
  - IDLE: a CS falling edge moves to NIB0. The nibble register and the final latch are cleared.
  - NIB0: on a DCLK rising edge, latch data into the high nibble and latch the final flag; go to NIB1.
  - NIB1: on a DCLK rising edge, latch data into the low nibble; go to EMIT.
  - EMIT (one cycle): drive pixel_out and pixel_valid_out=1 for exactly one cycle, with hcount_out/vcount_out holding this pixel's address. Then go to WAIT_END.
  - WAIT_END: a CS rising edge moves to IDLE. Further DCLK rising edges are ignored, and rx_error_out pulses once per extra edge.
- Malformed transactions: a CS rising edge in NIB0 or NIB1 drops the partial pixel, pulses rx_error_out, and returns to IDLE. No valid is produced and the address does not advance.
- Address update: applied in the cycle after EMIT.
  - hcount increments. At H_PIXELS-1 it wraps to 0 and vcount increments.
  - At (H_PIXELS-1, V_PIXELS-1) both wrap to 0.
- Final flag handling: if the final latch is set, both counters go to 0 regardless of position (resync), and frame_done_out pulses with that pixel's valid.
  - frame_done_out also pulses when the last pixel arrives with no final flag, i.e. natural wrap.
- Simultaneous events: a CS rising edge and a DCLK rising edge detected in the same cycle (possible only from synchronizer skew) are processed as the DCLK edge first, then the CS edge.
- Throughput: at most one pixel per transaction. Valid-to-valid spacing is at least 200 cycles at the default sender rate. No backpressure.

Optional Feature:
- Macro: SPI_RX_ERR_COUNT_EN.
- With the macro defined:
  - Adds output rx_err_count_out [15:0]. It increments on every rx_error_out pulse, saturates at 16'hFFFF, and resets to 0.
  - Adds output rx_pixel_count_out [23:0], which counts emitted pixels and wraps.
- Without the macro: neither port nor counter exists; rx_error_out is still present.

Test Plan:
- Sender model, DCLK half-period 50, CS low, nibbles 4'hA then 4'h5 -> one pixel_valid_out pulse with pixel_out=8'hA5, hcount=0, vcount=0. Second pixel 8'h3C -> hcount=1.
- Stream 160*90 pixels; final_pixel_in high on the last -> frame_done_out coincides with valid at (159,89). The next pixel is at (0,0).
- Final flag asserted on pixel at (10,5) -> frame_done_out pulses; the next pixel is at (0,0).
- CS rises after one nibble -> no valid, rx_error_out pulses once, address unchanged. The next complete transaction 8'h7E is at the unchanged address.
- Three DCLK rising edges in one transaction -> one valid, then one rx_error_out pulse.
- rst_in asserted mid-transaction with CS held low -> all outputs 0. No pixel is emitted until CS goes high; the next full transaction yields a correct pixel at (0,0).
